relogio_controle: RTL and testbench
===================================

# relogio_controle

Mode controller and timekeeping sequencer for the digital clock. It owns the running hh:mm:ss registers and the 1 Hz prescaler, and runs the adjust state machine that steps through the hour, minute and second fields. In adjust it captures switch values into shadow registers and commits them atomically. It drives the field-select and blink signals used by the display path.

## Interface
Parameters:
- CLK_HZ, 50_000_000, clk frequency; prescaler wraps every CLK_HZ cycles.
- BLINK_DIV, CLK_HZ/4, cycles per blink half-period (2 Hz blink at default).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_mode  in  1  raw, asynchronous; press enters adjust, or aborts adjust.
- btn_set  in  1  raw, asynchronous; press captures the current field and advances.
- sw  in  6  field value in unsigned binary.
- horas  out  6  running hours, 0..23.
- minutos  out  6  running minutes, 0..59.
- segundos  out  6  running seconds, 0..59.
- campo  out  2  field under adjust: 0 = none/RUN, 1 = hours, 2 = minutes, 3 = seconds.
- blink  out  1  blink phase; 1 = blank the field selected by campo.
- tick_1hz  out  1  one-cycle pulse on every running-time increment.
- adjust_done  out  1  one-cycle pulse on the cycle after a commit.

## Operation
- Button path:
  - Each button passes through a 2-flop synchronizer and a rising-edge detector, giving an internal one-cycle press pulse.
  - Holding a button produces exactly one pulse.
- States:
  - RUN: campo = 0; blink = 0.
  - ADJ_H, ADJ_M, ADJ_S: campo = 1, 2, 3.
- Transitions:
  - RUN + mode press -> ADJ_H. The shadow registers load the current running time.
  - ADJ_H + set press: shadow hours <= clamp(sw, 23); go to ADJ_M.
  - ADJ_M + set press: shadow minutes <= clamp(sw, 59); go to ADJ_S.
  - ADJ_S + set press: shadow seconds <= clamp(sw, 59). Commit all three shadows to the running registers; clear the prescaler; go to RUN; pulse adjust_done.
  - Any ADJ state + mode press: abort. No commit; go to RUN.
- Simultaneous mode and set presses: mode wins.
- Clamp rule: sw values above the field maximum saturate to the maximum. Examples: hours 6'd40 -> 23; minutes 6'd63 -> 59.
- Timekeeping:
  - The prescaler counts 0..CLK_HZ-1; each wrap issues tick_1hz.
  - Seconds 59 -> 0 carries into minutes; minutes 59 -> 0 carries into hours; hours 23 -> 0.
  - 23:59:59 + tick -> 00:00:00.
  - Running time keeps counting during adjust.
- A tick in the same cycle as a commit is discarded: commit wins, and the prescaler restarts from 0.
- Blink:
  - The counter runs only in the ADJ states and toggles blink every BLINK_DIV cycles.
  - Entering ADJ_H clears the counter and sets blink = 0.
  - Advancing between fields does not reset the phase.

## Timing
- Reset values, with reset low at any time including mid-adjust:
  - State RUN; horas = minutos = segundos = 0; campo = 0; blink = 0.
  - tick_1hz = 0; adjust_done = 0.
  - Prescaler, blink counter and shadows = 0; synchronizers = 0.
- Press latency:
  - btn first sampled high at edge N -> press pulse internal in cycle N+2.
  - State, campo and shadow update at edge N+3.
- Commit: running registers show the new time at edge N+3; adjust_done is high for the cycle after edge N+3.
- tick_1hz is registered and high in the same cycle the new time value first appears.
- sw is sampled only on the cycle of the set press pulse; it needs no stability outside that cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package relogio_pkg:
  - state_t enum {RUN, ADJ_H, ADJ_M, ADJ_S} with 2-bit encoding equal to campo.
  - Constants MAX_HORAS = 23 and MAX_MIN_SEG = 59.
  - A clamp function.
- Sub-module btn_edge: 2-flop synchronizer plus rising-edge pulse, with the same clk and reset. Instantiated once per button.
- The top level holds the FSM, prescaler, time counters, shadows and blink counter.

## Test plan
All scenarios use CLK_HZ = 10 and BLINK_DIV = 3.
- Reset release, 25 idle cycles -> tick_1hz at cycles 10 and 20; time 00:00:02; campo = 0.
- Preload 23:59:59 via adjust, then run 10 cycles -> next tick gives 00:00:00 with a single tick_1hz pulse.
- mode press; sw = 12, set; sw = 34, set; sw = 56, set:
  - campo steps 1 -> 2 -> 3 -> 0.
  - Time = 12:34:56 three cycles after the last press.
  - adjust_done is a one-cycle pulse.
- Clamp: in adjust, sw = 40 for hours, 63 for minutes, 60 for seconds -> commit gives 23:59:59.
- Abort and collision:
  - mode pressed in ADJ_M -> RUN with no time change and no adjust_done.
  - mode and set pressed on the same cycle in ADJ_H -> abort; shadow hours are not written.
- reset driven low mid-adjust at ADJ_S -> all outputs return to reset values asynchronously; no commit after release.

Source files
------------

// File: rtl/relogio_pkg.sv
// Shared types and helpers for the clock mode controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: state_t (encoding equals the campo field code), field maxima, clamp().
package relogio_pkg;

  // Encoding is chosen so the state register can drive campo directly.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ADJ_H = 2'd1,
    ADJ_M = 2'd2,
    ADJ_S = 2'd3
  } state_t;

  localparam logic [5:0] MAX_HORAS   = 6'd23;
  localparam logic [5:0] MAX_MIN_SEG = 6'd59;

  // Saturate a switch value to the field maximum.
  function automatic logic [5:0] clamp(input logic [5:0] v, input logic [5:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/relogio_controle_btn_edge.sv
// Button conditioner: 2-flop synchronizer, rising-edge detect, registered press pulse.
// Latency: btn_i first sampled high at edge N -> press_o high in the cycle after edge N+2.
// Backpressure: none; a held button yields exactly one pulse.
// Ports: clk, reset (async active-low), btn_i (raw async), press_o (one-cycle pulse).
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       press_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b00;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      prev_q  <= sync_q[1];
      press_q <= sync_q[1] & ~prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/relogio_controle.sv
// Digital clock mode controller: hh:mm:ss timekeeping, 1 Hz prescaler, field adjust FSM, blink.
// Latency: button press acts 3 edges after first sample; all outputs registered.
// Backpressure: none; presses are single-cycle pulses and are never queued.
// Ports: clk, reset (async active-low), btn_mode, btn_set, sw[5:0] in;
//        horas, minutos, segundos, campo, blink, tick_1hz, adjust_done out.
module relogio_controle
  import relogio_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BLINK_DIV = CLK_HZ / 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic [5:0] sw,
  output logic [5:0] horas,
  output logic [5:0] minutos,
  output logic [5:0] segundos,
  output logic [1:0] campo,
  output logic       blink,
  output logic       tick_1hz,
  output logic       adjust_done
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic mode_p, set_p;

  btn_edge u_btn_mode (.clk(clk), .reset(reset), .btn_i(btn_mode), .press_o(mode_p));
  btn_edge u_btn_set  (.clk(clk), .reset(reset), .btn_i(btn_set),  .press_o(set_p));

  state_t        state_q, state_d;
  logic [5:0]    h_q, h_d, m_q, m_d, s_q, s_d;
  logic [5:0]    sh_h_q, sh_h_d, sh_m_q, sh_m_d, sh_s_q, sh_s_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;
  logic          tick_q, tick_d;
  logic          done_q, done_d;
  logic          commit;

  // FSM and shadow registers; mode has priority over set.
  always_comb begin
    state_d = state_q;
    sh_h_d  = sh_h_q;
    sh_m_d  = sh_m_q;
    sh_s_d  = sh_s_q;
    commit  = 1'b0;
    unique case (state_q)
      RUN: if (mode_p) begin
        state_d = ADJ_H;
        sh_h_d  = h_q;
        sh_m_d  = m_q;
        sh_s_d  = s_q;
      end
      ADJ_H: if (mode_p) state_d = RUN;
      else if (set_p) begin
        sh_h_d  = clamp(sw, MAX_HORAS);
        state_d = ADJ_M;
      end
      ADJ_M: if (mode_p) state_d = RUN;
      else if (set_p) begin
        sh_m_d  = clamp(sw, MAX_MIN_SEG);
        state_d = ADJ_S;
      end
      ADJ_S: if (mode_p) state_d = RUN;
      else if (set_p) begin
        sh_s_d  = clamp(sw, MAX_MIN_SEG);
        commit  = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Timekeeping; a commit overrides a coincident tick and restarts the prescaler.
  always_comb begin
    presc_d = presc_q + 1'b1;
    h_d     = h_q;
    m_d     = m_q;
    s_d     = s_q;
    tick_d  = 1'b0;
    if (presc_q == PW'(CLK_HZ - 1)) begin
      presc_d = '0;
      tick_d  = 1'b1;
      if (s_q == MAX_MIN_SEG) begin
        s_d = 6'd0;
        if (m_q == MAX_MIN_SEG) begin
          m_d = 6'd0;
          h_d = (h_q == MAX_HORAS) ? 6'd0 : h_q + 1'b1;
        end else begin
          m_d = m_q + 1'b1;
        end
      end else begin
        s_d = s_q + 1'b1;
      end
    end
    if (commit) begin
      presc_d = '0;
      tick_d  = 1'b0;
      h_d     = sh_h_q;
      m_d     = sh_m_q;
      s_d     = sh_s_d;
    end
    done_d = commit;
  end

  // Blink phase: held at 0 in RUN and on entry to ADJ_H; free-runs across field advances.
  always_comb begin
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    if (state_q == RUN || state_d == RUN) begin
      bcnt_d  = '0;
      blink_d = 1'b0;
    end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
      bcnt_d  = '0;
      blink_d = ~blink_q;
    end else begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      h_q     <= '0;
      m_q     <= '0;
      s_q     <= '0;
      sh_h_q  <= '0;
      sh_m_q  <= '0;
      sh_s_q  <= '0;
      presc_q <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      m_q     <= m_d;
      s_q     <= s_d;
      sh_h_q  <= sh_h_d;
      sh_m_q  <= sh_m_d;
      sh_s_q  <= sh_s_d;
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign horas       = h_q;
  assign minutos     = m_q;
  assign segundos    = s_q;
  assign campo       = state_q;
  assign blink       = blink_q;
  assign tick_1hz    = tick_q;
  assign adjust_done = done_q;

endmodule

// File: tb/tb_relogio_controle.sv
// Testbench for relogio_controle with CLK_HZ = 10 and BLINK_DIV = 3.
// The reference model keeps time as seconds-of-day and tracks the adjust field
// as a small integer; outputs are compared every cycle at the falling edge.
module tb_relogio_controle;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_set;
  logic [5:0] sw;
  logic [5:0] horas, minutos, segundos;
  logic [1:0] campo;
  logic       blink, tick_1hz, adjust_done;

  relogio_controle #(.CLK_HZ(10), .BLINK_DIV(3)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_set(btn_set), .sw(sw),
    .horas(horas), .minutos(minutos), .segundos(segundos), .campo(campo),
    .blink(blink), .tick_1hz(tick_1hz), .adjust_done(adjust_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model state
  int tod;     // seconds of day
  int ph;      // cycles since last prescaler restart
  int fld;     // 0 run, 1 hours, 2 minutes, 3 seconds
  int adjc;    // cycles spent in adjust since entering hours
  int sh_h, sh_m, sh_s;
  int e_tick, e_done;
  int ntick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    tod = 0; ph = 0; fld = 0; adjc = 0;
    sh_h = 0; sh_m = 0; sh_s = 0;
    e_tick = 0; e_done = 0;
  endtask

  task automatic check_all();
    int eb;
    eb = (fld != 0 && ((adjc / 3) % 2) == 1) ? 1 : 0;
    chk("horas", 32'(horas), tod / 3600);
    chk("minutos", 32'(minutos), (tod / 60) % 60);
    chk("segundos", 32'(segundos), tod % 60);
    chk("campo", 32'(campo), fld);
    chk("blink", 32'(blink), eb);
    chk("tick_1hz", 32'(tick_1hz), e_tick);
    chk("adjust_done", 32'(adjust_done), e_done);
  endtask

  // act: 0 none, 1 mode press reaches the FSM, 2 set press reaches the FSM.
  task automatic step(input int act);
    int prev_fld;
    int commit;
    @(posedge clk);
    prev_fld = fld;
    commit   = 0;
    e_done   = 0;
    if (act == 1) begin
      if (fld == 0) begin
        fld = 1; sh_h = tod / 3600; sh_m = (tod / 60) % 60; sh_s = tod % 60;
      end else begin
        fld = 0;
      end
    end else if (act == 2 && fld != 0) begin
      if (fld == 1) begin sh_h = sat(int'(sw), 23); fld = 2; end
      else if (fld == 2) begin sh_m = sat(int'(sw), 59); fld = 3; end
      else begin sh_s = sat(int'(sw), 59); fld = 0; commit = 1; end
    end
    if (fld == 0 || prev_fld == 0) adjc = 0;
    else adjc++;
    if (commit) begin
      tod = sh_h * 3600 + sh_m * 60 + sh_s;
      ph = 0; e_tick = 0; e_done = 1;
    end else if (ph == 9) begin
      ph = 0; tod = (tod + 1) % 86400; e_tick = 1;
    end else begin
      ph++; e_tick = 0;
    end
    @(negedge clk);
    if (tick_1hz === 1'b1) ntick++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0);
  endtask

  // Raise the button(s); v is the switch value present only on the pulse cycle.
  task automatic press(input bit m, input bit s, input logic [5:0] v);
    sw = 6'($urandom_range(0, 63));
    btn_mode = m;
    btn_set  = s;
    step(0); step(0); step(0);
    sw = v;
    step(m ? 1 : (s ? 2 : 0));
    sw = 6'($urandom_range(0, 63));
    step(0); step(0);
    btn_mode = 1'b0;
    btn_set  = 1'b0;
    idle(3);
  endtask

  task automatic adjust_to(input logic [5:0] hh, input logic [5:0] mm, input logic [5:0] ss);
    press(1, 0, 6'd0);
    press(0, 1, hh);
    press(0, 1, mm);
    press(0, 1, ss);
  endtask

  initial begin
    reset = 1'b0; btn_mode = 1'b0; btn_set = 1'b0; sw = 6'd0;
    model_reset();
    ntick = 0;
    repeat (3) @(negedge clk);
    check_all();
    reset = 1'b1;

    // Idle from reset: ticks at cycles 10 and 20, 00:00:02 after 25 cycles.
    idle(25);
    chk("ticks_in_25", ntick, 2);
    chk("seg_after_25", 32'(segundos), 2);

    // Preload 23:59:59 and roll over to midnight.
    adjust_to(6'd23, 6'd59, 6'd59);
    ntick = 0;
    idle(10);
    chk("midnight_ticks", ntick, 1);
    chk("midnight_h", 32'(horas), 0);

    // Directed adjust to 12:34:56.
    adjust_to(6'd12, 6'd34, 6'd56);

    // Clamp: out-of-range switch values saturate.
    adjust_to(6'd40, 6'd63, 6'd60);

    // Abort in minutes field.
    press(1, 0, 6'd0);
    press(0, 1, 6'd5);
    press(1, 0, 6'd0);
    idle(4);

    // Mode and set together in hours field: abort wins.
    press(1, 0, 6'd0);
    press(1, 1, 6'd7);
    idle(4);

    // Randomized adjust sequences, some aborted in the minutes field.
    for (int k = 0; k < 6; k++) begin
      press(1, 0, 6'd0);
      idle($urandom_range(0, 12));
      press(0, 1, 6'($urandom_range(0, 63)));
      idle($urandom_range(0, 12));
      if (k % 3 == 2) begin
        press(1, 0, 6'd0);
      end else begin
        press(0, 1, 6'($urandom_range(0, 63)));
        idle($urandom_range(0, 12));
        press(0, 1, 6'($urandom_range(0, 63)));
      end
      idle($urandom_range(0, 20));
    end

    // Asynchronous reset while in the seconds field.
    press(1, 0, 6'd0);
    press(0, 1, 6'd9);
    press(0, 1, 6'd9);
    chk("in_adj_s", 32'(campo), 3);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(15);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
